// File: rtl/alu_mul_seq.sv
// Sequential 64x64 -> 128-bit unsigned multiplier (shift-and-add) that borrows
// the shared EX-stage ALU as its adder, one add per cycle for 64 cycles.
//
// state  | meaning
// S_IDLE | waiting for start; ALU released, product registers hold last result
// S_RUN  | owns the ALU; one shift-and-add iteration per clock
// S_DONE | one-cycle done pulse; product registers updated on entry
module alu_mul_seq #(
   parameter logic [2:0] ADD_CTRL = 3'b010
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        flush,
   input  logic [63:0] mcand,
   input  logic [63:0] mplier,
   input  logic [63:0] alu_out,
   input  logic        alu_cout,
   output logic        alu_own,
   output logic [63:0] alu_a,
   output logic [63:0] alu_b,
   output logic [2:0]  alu_ctrl,
   output logic        busy,
   output logic        done,
   output logic [63:0] prod_hi,
   output logic [63:0] prod_lo,
   output logic        prod_zero
);

   localparam int         ITER     = 64;
   localparam logic [6:0] CNT_LAST = 7'(ITER - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      state;
   logic [63:0] hi;
   logic [63:0] lo;
   logic [63:0] mc;
   logic [6:0]  cnt;
   logic [63:0] hi_nxt;
   logic [63:0] lo_nxt;

   // The 65-bit sum {cout, out} is shifted right by one across the hi:lo pair.
   assign hi_nxt = {alu_cout, alu_out[63:1]};
   assign lo_nxt = {alu_out[0], lo[63:1]};

   assign alu_a    = alu_own ? hi : 64'd0;
   assign alu_b    = (alu_own && lo[0]) ? mc : 64'd0;
   assign alu_ctrl = alu_own ? ADD_CTRL : 3'b000;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         hi        <= 64'd0;
         lo        <= 64'd0;
         mc        <= 64'd0;
         cnt       <= 7'd0;
         alu_own   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         prod_hi   <= 64'd0;
         prod_lo   <= 64'd0;
         prod_zero <= 1'b1;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start && !flush) begin
                  mc      <= mcand;
                  lo      <= mplier;
                  hi      <= 64'd0;
                  cnt     <= 7'd0;
                  state   <= S_RUN;
                  busy    <= 1'b1;
                  alu_own <= 1'b1;
               end
            end
            S_RUN: begin
               if (flush) begin
                  state   <= S_IDLE;
                  busy    <= 1'b0;
                  alu_own <= 1'b0;
               end else begin
                  hi  <= hi_nxt;
                  lo  <= lo_nxt;
                  cnt <= cnt + 7'd1;
                  if (cnt == CNT_LAST) begin
                     state     <= S_DONE;
                     busy      <= 1'b0;
                     alu_own   <= 1'b0;
                     done      <= 1'b1;
                     prod_hi   <= hi_nxt;
                     prod_lo   <= lo_nxt;
                     prod_zero <= ~|{hi_nxt, lo_nxt};
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state   <= S_IDLE;
               busy    <= 1'b0;
               alu_own <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: models the shared ALU as a plain adder and compares
// each product against a 128-bit arithmetic reference.
module tb_alu_mul_seq;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic        flush;
   logic [63:0] mcand;
   logic [63:0] mplier;
   logic [63:0] alu_out;
   logic        alu_cout;
   logic        alu_own;
   logic [63:0] alu_a;
   logic [63:0] alu_b;
   logic [2:0]  alu_ctrl;
   logic        busy;
   logic        done;
   logic [63:0] prod_hi;
   logic [63:0] prod_lo;
   logic        prod_zero;

   int pass_cnt  = 0;
   int total_cnt = 0;

   alu_mul_seq dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .flush    (flush),
      .mcand    (mcand),
      .mplier   (mplier),
      .alu_out  (alu_out),
      .alu_cout (alu_cout),
      .alu_own  (alu_own),
      .alu_a    (alu_a),
      .alu_b    (alu_b),
      .alu_ctrl (alu_ctrl),
      .busy     (busy),
      .done     (done),
      .prod_hi  (prod_hi),
      .prod_lo  (prod_lo),
      .prod_zero(prod_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Shared ALU: only the add code produces a result, carry-in fixed at 0.
   always_comb begin
      {alu_cout, alu_out} = 65'd0;
      if (alu_ctrl == 3'b010)
         {alu_cout, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Launch one multiply and wait (bounded) for done; lat = edges after acceptance, -1 on timeout.
   task automatic do_mul(input logic [63:0] a, input logic [63:0] b,
                         output int lat, output int nbusy, output bit cout_seen,
                         output bit bnz_seen, output bit ctrl_ok, output logic done_after);
      start = 1'b1; mcand = a; mplier = b;
      step();
      start = 1'b0; mcand = $urandom; mplier = $urandom;
      lat = -1; nbusy = 0; cout_seen = 0; bnz_seen = 0; ctrl_ok = 1; done_after = 1'bx;
      for (int i = 0; i < 200; i++) begin
         if (done) begin
            lat = i;
            break;
         end
         if (busy) begin
            nbusy++;
            if (alu_cout) cout_seen = 1;
            if (alu_b != 64'd0) bnz_seen = 1;
            if (!alu_own || alu_ctrl != 3'b010) ctrl_ok = 0;
         end
         step();
      end
      if (lat >= 0) begin
         step();
         done_after = done;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start = 1'b0; flush = 1'b0; mcand = '0; mplier = '0;
      step(); step();
      total_cnt++; if ({alu_own, busy, done} !== 3'b000) $display("FAIL reset_flags got %b want 000", {alu_own, busy, done}); else pass_cnt++;
      total_cnt++; if ({alu_a, alu_b, alu_ctrl} !== 131'd0) $display("FAIL reset_alu got a=%h b=%h c=%b want 0", alu_a, alu_b, alu_ctrl); else pass_cnt++;
      total_cnt++; if ({prod_hi, prod_lo} !== 128'd0) $display("FAIL reset_prod got %h_%h want 0", prod_hi, prod_lo); else pass_cnt++;
      total_cnt++; if (prod_zero !== 1'b1) $display("FAIL reset_zero got %b want 1", prod_zero); else pass_cnt++;
      reset_n = 1'b1;
      step();
      total_cnt++; if (busy !== 1'b0) $display("FAIL reset_idle_busy got %b want 0", busy); else pass_cnt++;
   endtask

   task automatic test_basic();
      int lat, nbusy; bit cs, bnz, cok; logic da;
      do_mul(64'd3, 64'd5, lat, nbusy, cs, bnz, cok, da);
      total_cnt++; if (lat != 64) $display("FAIL t1_latency got %0d want 64", lat); else pass_cnt++;
      total_cnt++; if (nbusy != 64) $display("FAIL t1_busy_cycles got %0d want 64", nbusy); else pass_cnt++;
      total_cnt++; if (cok !== 1'b1) $display("FAIL t1_alu_ctrl got %b want 1", cok); else pass_cnt++;
      total_cnt++; if ({prod_hi, prod_lo} !== 128'd15) $display("FAIL t1_prod got %h_%h want 15", prod_hi, prod_lo); else pass_cnt++;
      total_cnt++; if (prod_zero !== 1'b0) $display("FAIL t1_zero got %b want 0", prod_zero); else pass_cnt++;
      total_cnt++; if (da !== 1'b0) $display("FAIL t1_done_pulse got %b want 0", da); else pass_cnt++;
   endtask

   task automatic test_allones();
      int lat, nbusy; bit cs, bnz, cok; logic da;
      do_mul({64{1'b1}}, {64{1'b1}}, lat, nbusy, cs, bnz, cok, da);
      total_cnt++; if (prod_hi !== 64'hFFFF_FFFF_FFFF_FFFE) $display("FAIL t2_hi got %h want fffffffffffffffe", prod_hi); else pass_cnt++;
      total_cnt++; if (prod_lo !== 64'h1) $display("FAIL t2_lo got %h want 1", prod_lo); else pass_cnt++;
      total_cnt++; if (cs !== 1'b1) $display("FAIL t2_cout_seen got %b want 1", cs); else pass_cnt++;
   endtask

   task automatic test_zero();
      int lat, nbusy; bit cs, bnz, cok; logic da;
      do_mul(64'h1234, 64'd0, lat, nbusy, cs, bnz, cok, da);
      total_cnt++; if ({prod_hi, prod_lo} !== 128'd0) $display("FAIL t3_prod got %h_%h want 0", prod_hi, prod_lo); else pass_cnt++;
      total_cnt++; if (prod_zero !== 1'b1) $display("FAIL t3_zero got %b want 1", prod_zero); else pass_cnt++;
      total_cnt++; if (bnz !== 1'b0) $display("FAIL t3_alu_b_nonzero got %b want 0", bnz); else pass_cnt++;
   endtask

   task automatic test_random();
      int lat, nbusy; bit cs, bnz, cok; logic da;
      logic [63:0] a, b; logic [127:0] exp;
      for (int n = 0; n < 10; n++) begin
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         if (n == 0) a[63] = 1'b1;
         if (n == 1) b = 64'd1;
         exp = {64'd0, a} * {64'd0, b};
         do_mul(a, b, lat, nbusy, cs, bnz, cok, da);
         total_cnt++; if (lat != 64) $display("FAIL rnd%0d_latency got %0d want 64", n, lat); else pass_cnt++;
         total_cnt++; if ({prod_hi, prod_lo} !== exp) $display("FAIL rnd%0d_prod a=%h b=%h got %h_%h want %h", n, a, b, prod_hi, prod_lo, exp); else pass_cnt++;
         total_cnt++; if (prod_zero !== (exp == 128'd0)) $display("FAIL rnd%0d_zero got %b want %b", n, prod_zero, exp == 128'd0); else pass_cnt++;
      end
   endtask

   task automatic test_back_to_back();
      int lat, nbusy; bit cs, bnz, cok; logic da;
      logic [63:0] a, b; logic [127:0] exp;
      int seen;
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      exp = {64'd0, a} * {64'd0, b};
      start = 1'b1; mcand = a; mplier = b;
      step();
      start = 1'b0;
      for (int i = 1; i < 10; i++) step();
      start = 1'b1; mcand = 64'd2; mplier = 64'd2;
      step();
      start = 1'b0;
      seen = -1;
      for (int i = 10; i < 200; i++) begin
         if (done) begin seen = i; break; end
         step();
      end
      total_cnt++; if (seen != 64) $display("FAIL t4_ignored_latency got %0d want 64", seen); else pass_cnt++;
      total_cnt++; if ({prod_hi, prod_lo} !== exp) $display("FAIL t4_ignored_prod got %h_%h want %h", prod_hi, prod_lo, exp); else pass_cnt++;
      step();
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      exp = {64'd0, a} * {64'd0, b};
      do_mul(a, b, lat, nbusy, cs, bnz, cok, da);
      total_cnt++; if (lat != 64) $display("FAIL t4_b2b_latency got %0d want 64", lat); else pass_cnt++;
      total_cnt++; if ({prod_hi, prod_lo} !== exp) $display("FAIL t4_b2b_prod got %h_%h want %h", prod_hi, prod_lo, exp); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      int lat, nbusy; bit cs, bnz, cok; logic da;
      int ndone;
      start = 1'b1; mcand = 64'hDEAD_BEEF; mplier = 64'h1234_5678_9ABC;
      step();
      start = 1'b0;
      for (int i = 1; i < 30; i++) step();
      reset_n = 1'b0;
      #1;
      total_cnt++; if ({alu_own, busy, done} !== 3'b000) $display("FAIL t5_flags got %b want 000", {alu_own, busy, done}); else pass_cnt++;
      total_cnt++; if ({alu_a, alu_b, alu_ctrl} !== 131'd0) $display("FAIL t5_alu got a=%h b=%h c=%b want 0", alu_a, alu_b, alu_ctrl); else pass_cnt++;
      total_cnt++; if ({prod_hi, prod_lo} !== 128'd0) $display("FAIL t5_prod got %h_%h want 0", prod_hi, prod_lo); else pass_cnt++;
      total_cnt++; if (prod_zero !== 1'b1) $display("FAIL t5_zero got %b want 1", prod_zero); else pass_cnt++;
      step(); step();
      reset_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 70; i++) begin
         step();
         if (done) ndone++;
      end
      total_cnt++; if (ndone != 0) $display("FAIL t5_no_done got %0d want 0", ndone); else pass_cnt++;
      do_mul(64'd7, 64'd9, lat, nbusy, cs, bnz, cok, da);
      total_cnt++; if ({prod_hi, prod_lo} !== 128'd63) $display("FAIL t5_after_prod got %h_%h want 63", prod_hi, prod_lo); else pass_cnt++;
   endtask

   task automatic test_flush();
      int lat, nbusy; bit cs, bnz, cok; logic da;
      logic [63:0] a, b; logic [127:0] prior;
      int ndone;
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      prior = {64'd0, a} * {64'd0, b};
      do_mul(a, b, lat, nbusy, cs, bnz, cok, da);
      start = 1'b1; mcand = 64'hFFFF_0000_FFFF; mplier = 64'h7777_7777;
      step();
      start = 1'b0;
      for (int i = 1; i < 40; i++) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      total_cnt++; if ({alu_own, busy, done} !== 3'b000) $display("FAIL t6_flush_flags got %b want 000", {alu_own, busy, done}); else pass_cnt++;
      total_cnt++; if ({alu_a, alu_b, alu_ctrl} !== 131'd0) $display("FAIL t6_flush_alu got a=%h b=%h c=%b want 0", alu_a, alu_b, alu_ctrl); else pass_cnt++;
      ndone = 0;
      for (int i = 0; i < 70; i++) begin
         if (done || busy) ndone++;
         step();
      end
      total_cnt++; if (ndone != 0) $display("FAIL t6_no_done got %0d want 0", ndone); else pass_cnt++;
      total_cnt++; if ({prod_hi, prod_lo} !== prior) $display("FAIL t6_prod_kept got %h_%h want %h", prod_hi, prod_lo, prior); else pass_cnt++;
      flush = 1'b1; start = 1'b1; mcand = 64'd5; mplier = 64'd5;
      step();
      flush = 1'b0; start = 1'b0;
      total_cnt++; if ({busy, alu_own} !== 2'b00) $display("FAIL t6_flush_start got %b want 00", {busy, alu_own}); else pass_cnt++;
      step();
      total_cnt++; if (busy !== 1'b0) $display("FAIL t6_stays_idle got %b want 0", busy); else pass_cnt++;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_allones();
      test_zero();
      test_random();
      test_back_to_back();
      test_reset_mid();
      test_flush();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
